// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC generator for the MIPS fetch stage.
// Optional alignment fault trap is enabled by defining PC_ALIGN_CHECK_EN.
module pc_next_unit #(
    parameter int          ADDR_W     = 32,
    parameter int          TGT_W      = 26,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [TGT_W-1:0]  jump_target,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_4,
    output logic [ADDR_W-1:0] link_addr,
    output logic              redirect_pending,
    output logic              addr_err
);

    localparam int                RGN_W      = ADDR_W - TGT_W - 2;
    localparam logic [ADDR_W-1:0] L_RESET_PC = ADDR_W'(RESET_PC);

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_next;
    logic [ADDR_W-1:0]   r_buf;
    logic [ADDR_W-1:0]   w_buf_next;
    logic                r_addr_err;
    logic                w_addr_err_next;

    logic [ADDR_W-1:0]   w_pc_plus_4;
    logic [ADDR_W+17:0]  w_br_ext;
    logic [ADDR_W-1:0]   w_br_tgt;
    logic [ADDR_W-1:0]   w_j_tgt;
    logic                w_sel_valid;
    logic [ADDR_W-1:0]   w_sel_tgt;
    logic [ADDR_W-1:0]   w_raw_tgt;
    logic [ADDR_W-1:0]   w_load_pc;
    logic                w_misaligned;

    if (RGN_W < 0) begin : g_param_check
        $error("pc_next_unit: ADDR_W must be >= TGT_W+2");
    end

    assign w_pc_plus_4 = r_pc + ADDR_W'(4);
    assign w_br_ext    = {{ADDR_W{branch_imm[15]}}, branch_imm, 2'b00};
    assign w_br_tgt    = w_pc_plus_4 + w_br_ext[ADDR_W-1:0];

    // With no region bits the target field alone spans the address.
    if (RGN_W > 0) begin : g_jtgt_rgn
        assign w_j_tgt = {w_pc_plus_4[ADDR_W-1 -: RGN_W], jump_target, 2'b00};
    end else begin : g_jtgt_full
        assign w_j_tgt = {jump_target, 2'b00};
    end

    always_comb begin
        w_sel_valid = jump_reg | jump | branch_taken;
        if (jump_reg) begin
            w_sel_tgt = jr_addr;
        end else if (jump) begin
            w_sel_tgt = w_j_tgt;
        end else if (branch_taken) begin
            w_sel_tgt = w_br_tgt;
        end else begin
            w_sel_tgt = w_pc_plus_4;
        end
    end

    // A buffered redirect always wins over whatever is requested in that cycle.
    assign w_raw_tgt    = (r_state == ST_PEND) ? r_buf : w_sel_tgt;
    assign w_misaligned = (w_raw_tgt[1:0] != 2'b00);

`ifdef PC_ALIGN_CHECK_EN
    assign w_load_pc = w_misaligned ? ADDR_W'(EXC_VECTOR) : w_raw_tgt;
`else
    logic w_unused_bits;
    assign w_load_pc     = {w_raw_tgt[ADDR_W-1:2], 2'b00};
    assign w_unused_bits = ^{EXC_VECTOR, w_misaligned};
`endif

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_buf_next      = r_buf;
        w_addr_err_next = 1'b0;
        if (!stall) begin
            w_pc_next       = w_load_pc;
            w_state_next    = ST_IDLE;
            w_addr_err_next = w_misaligned;
        end else if ((r_state == ST_IDLE) && w_sel_valid) begin
            w_buf_next   = w_sel_tgt;
            w_state_next = ST_PEND;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= L_RESET_PC;
            r_buf      <= '0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_buf      <= w_buf_next;
            r_addr_err <= w_addr_err_next;
        end
    end

    assign pc               = r_pc;
    assign pc_plus_4        = w_pc_plus_4;
    assign link_addr        = r_pc + ADDR_W'(8);
    assign redirect_pending = (r_state == ST_PEND);

`ifdef PC_ALIGN_CHECK_EN
    assign addr_err = r_addr_err;
`else
    logic w_unused_err;
    assign addr_err     = 1'b0;
    assign w_unused_err = r_addr_err;
`endif

    logic w_unused_ext;
    assign w_unused_ext = ^w_br_ext[ADDR_W+17:ADDR_W];

endmodule
